// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-32 control FSM.
// States, opcodes, mux select codes and the strobe bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JAL       = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] B_RT     = 2'b00;
  localparam logic [1:0] B_FOUR   = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder: maps the current state to datapath strobes.
// TRAP and unused codes decode to all-zero.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = B_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RT;
        ctrl.wb_sel     = WB_MDR;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = B_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RD;
        ctrl.wb_sel     = WB_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RT;
        ctrl.wb_sel     = WB_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = B_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_R31;
        ctrl.wb_sel     = WB_PC;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS-32 control FSM: state register, sequencing, reset gate.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wb_sel,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  dec;
  ctrl_t  ctrl;
  logic   unused_zero;

  // zero gates pc_write_cond in the datapath, not here
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          OP_ADDI:      state_d = S_ADDI_EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:
        state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    state_d = S_MEM_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic ill_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ill_q <= 1'b0;
    else if (state_d == S_TRAP) ill_q <= 1'b1;
  end

  assign illegal_op = ill_q & ~reset;
`else
  assign illegal_op = 1'b0;
`endif

  mips_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (dec)
  );

  // reset overrides the FETCH decode so nothing strobes while held
  assign ctrl = reset ? '0 : dec;

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ir_write      = ctrl.ir_write;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign wb_sel        = ctrl.wb_sel;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_src        = ctrl.pc_src;
  assign instr_done    = ctrl.instr_done;
  assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl with a per-instruction
// cycle-table model; honours ILLEGAL_OP_TRAP_EN like the design.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic pw, pwc, irw, mr, mw, iod, rw;
    logic [1:0] rd, wb;
    logic asa;
    logic [1:0] asb, aop, psrc;
    logic done, ill;
  } ob_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011;
  localparam logic [5:0] ADDI = 6'b001000, BAD = 6'b111111;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode;
  logic zero;
  logic pc_write, pc_write_cond, ir_write, mem_read, mem_write;
  logic i_or_d, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] reg_dst, wb_sel, alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int total = 0;
  int bad = 0;
  int exp_done = 0;
  int done_seen = 0;
  logic chk_en = 1'b0;
  ob_t exp_v = '0;
  ob_t act;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, J, JAL, ADDI};
  endfunction

  function automatic int ilen(input logic [5:0] op);
    case (op)
      LW: return 5;
      SW, RT, ADDI: return 4;
      BEQ, J, JAL: return 3;
      default: return 2;
    endcase
  endfunction

  // expected outputs in cycle s of an instruction (s=0 is FETCH)
  function automatic ob_t model(input logic [5:0] op, input int s);
    ob_t o = '0;
    if (s == 0) begin
      o.pw = 1; o.irw = 1; o.mr = 1; o.asb = 2'b01;
    end else if (s == 1) begin
      o.st = 4'd1; o.asb = 2'b11;
    end else begin
      case (op)
        LW, SW:
          if (s == 2) begin
            o.st = 4'd2; o.asa = 1; o.asb = 2'b10;
          end else if (op == SW) begin
            o.st = 4'd5; o.mw = 1; o.iod = 1; o.done = 1;
          end else if (s == 3) begin
            o.st = 4'd3; o.mr = 1; o.iod = 1;
          end else begin
            o.st = 4'd4; o.rw = 1; o.wb = 2'b01; o.done = 1;
          end
        RT:
          if (s == 2) begin
            o.st = 4'd6; o.asa = 1; o.aop = 2'b10;
          end else begin
            o.st = 4'd7; o.rw = 1; o.rd = 2'b01; o.done = 1;
          end
        ADDI:
          if (s == 2) begin
            o.st = 4'd11; o.asa = 1; o.asb = 2'b10;
          end else begin
            o.st = 4'd12; o.rw = 1; o.done = 1;
          end
        BEQ: begin
          o.st = 4'd8; o.asa = 1; o.aop = 2'b01;
          o.pwc = 1; o.psrc = 2'b01; o.done = 1;
        end
        J: begin
          o.st = 4'd9; o.pw = 1; o.psrc = 2'b10; o.done = 1;
        end
        JAL: begin
          o.st = 4'd10; o.pw = 1; o.psrc = 2'b10; o.rw = 1;
          o.rd = 2'b10; o.wb = 2'b10; o.done = 1;
        end
        default: begin
          o.st = 4'd13; o.ill = 1;
        end
      endcase
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      act = {state, pc_write, pc_write_cond, ir_write, mem_read,
             mem_write, i_or_d, reg_write, reg_dst, wb_sel,
             alu_src_a, alu_src_b, alu_op, pc_src, instr_done,
             illegal_op};
      check("cycle", 32'(act), 32'(exp_v));
      if (instr_done === 1'b1) done_seen++;
    end
  end

  task automatic setup(input logic [5:0] op, input int s);
    opcode = (s == 0) ? 6'($urandom) : op;
    zero = 1'($urandom);
    exp_v = model(op, s);
    if (exp_v.done) exp_done++;
  endtask

  task automatic run(input logic [5:0] op, input int s0, input int n);
    for (int s = s0; s < n; s++) begin
      setup(op, s);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    exp_v = '0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op;
    logic [5:0] tbl [7];
    tbl = '{LW, SW, RT, BEQ, J, JAL, ADDI};
    reset = 1'b1;
    opcode = '0;
    zero = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #1;
    check("rst_strobes", {29'd0, pc_write, ir_write, mem_read}, 0);
    do_reset(2);

    setup(LW, 0);
    @(negedge clk); #1;
    check("rel_state", 32'(state), 0);
    check("rel_fetch", {29'd0, pc_write, ir_write, mem_read}, 7);
    @(posedge clk); #1;
    run(LW, 1, 4);
    setup(LW, 4);
    @(negedge clk); #1;
    check("lw_wb", {29'd0, reg_write, wb_sel}, 3'b101);
    @(posedge clk); #1;

    run(SW, 0, 4);
    run(BEQ, 0, 3);
    run(BEQ, 0, 3);
    run(JAL, 0, 2);
    setup(JAL, 2);
    @(negedge clk); #1;
    check("jal", {25'd0, pc_src, reg_dst, wb_sel, reg_write},
          7'b1010101);
    @(posedge clk); #1;

`ifdef ILLEGAL_OP_TRAP_EN
    run(BAD, 0, 12);
    setup(BAD, 12);
    @(negedge clk); #1;
    check("trap", {27'd0, illegal_op, state}, 5'b11101);
    @(posedge clk); #1;
    do_reset(2);
`else
    run(BAD, 0, 2);
    setup(J, 0);
    @(negedge clk); #1;
    check("no_trap", {27'd0, illegal_op, state}, 0);
    @(posedge clk); #1;
    run(J, 1, 3);
`endif

    run(LW, 0, 3);
    setup(LW, 3);
    @(negedge clk); #2;
    reset = 1'b1;
    exp_v = '0;
    #1;
    check("abort_state", 32'(state), 0);
    check("abort_mr", {31'd0, mem_read}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 7) op = 6'($urandom);
      else op = tbl[$urandom_range(0, 6)];
`ifdef ILLEGAL_OP_TRAP_EN
      if (!legal(op)) begin
        run(op, 0, 5);
        do_reset(2);
        continue;
      end
`endif
      run(op, 0, ilen(op));
    end

    setup(J, 0);
    @(negedge clk); #1;
    chk_en = 1'b0;
    check("done_cnt", 32'(done_seen), 32'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore control FSM for the multi-cycle MIPS-32 datapath. It decodes the latched opcode and drives every datapath strobe. It also drives the 2-bit select pairs (pc_src, wb_sel, reg_dst, alu_src_b) that feed the 4:1 muxes directly downstream: next-PC, writeback data, destination register and ALU B operand. One instruction takes 3–5 cycles.

Parameters:
OPCODE_W, 6, opcode field width
STATE_W, 4, state register width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state FETCH
opcode  input  OPCODE_W  instr[31:26] from instruction register, valid from DECODE onward
zero  input  1  ALU zero flag, sampled in BRANCH
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero
ir_write  output  1  instruction register load
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
i_or_d  output  1  0=PC address, 1=ALUOut address
reg_write  output  1  register file write
reg_dst  output  2  00=rt, 01=rd, 10=r31
wb_sel  output  2  00=ALUOut, 01=MDR, 10=PC, 11=reserved
alu_src_a  output  1  0=PC, 1=rs
alu_src_b  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct-decode
pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=reserved
instr_done  output  1  one-cycle pulse in final state of each instruction
illegal_op  output  1  sticky illegal-opcode flag
state  output  STATE_W  current state, for debug

Behaviour:
- Interface (decided): single clock clk. reset is asynchronous and active-high.
- While reset is high: state=FETCH. All strobes, selects, alu_op, instr_done and illegal_op are 0, overriding the FETCH decode. FETCH outputs appear the first cycle after release.
- Outputs are Moore: a pure function of state. The only exception is that pc_write_cond is gated with zero inside the datapath, not here.
- Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, JAL=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=13. Codes 14/15 return to FETCH.
- FETCH: mem_read, ir_write, pc_write; alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by opcode:
  - 100011 or 101011 → MEM_ADDR
  - 000000 → R_EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - 001000 → ADDI_EXEC
  - any other opcode → see Optional Feature
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read, i_or_d=1. Next state: MEM_WB.
- MEM_WB: reg_write, reg_dst=00, wb_sel=01, instr_done.
- MEM_WR: mem_write, i_or_d=1, instr_done.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state: R_WB.
- R_WB: reg_write, reg_dst=01, wb_sel=00, instr_done.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: ADDI_WB.
- ADDI_WB: reg_write, reg_dst=00, wb_sel=00, instr_done.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_src=01, instr_done.
- JUMP: pc_write, pc_src=10, instr_done.
- JAL: pc_write, pc_src=10, reg_write, reg_dst=10, wb_sel=10, instr_done.
- Every state that asserts instr_done transitions to FETCH.
- Cycle counts including FETCH: lw 5; sw, R, addi 4; beq, j, jal 3.
- Reserved select code 11 is never driven.
- Reset asserted mid-instruction aborts it immediately. No strobe may be high in the cycle reset rises.

Optional Feature:
Macro ILLEGAL_OP_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. In TRAP, illegal_op goes high and stays high, all strobes are 0, and the FSM remains in TRAP until reset.
- Undefined: an unknown opcode in DECODE goes to FETCH with no strobes and no instr_done. illegal_op is tied 0 and TRAP is unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI)
  - pc_src, wb_sel, reg_dst, alu_src_b and alu_op encodings
- One sub-module: mips_ctrl_outdec, the combinational state→output decoder. The top level keeps the state register, next-state logic, reset override and illegal flag.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0 during reset; next cycle state=0, pc_write=ir_write=mem_read=1.
- opcode=100011 (lw) → states 0,1,2,3,4,0; reg_write=1 with wb_sel=01 in cycle 5 only; instr_done once.
- opcode=101011 (sw) → states 0,1,2,5,0; mem_write=1, i_or_d=1 in cycle 4; reg_write never high.
- opcode=000100, zero=1, then again with zero=0 → both take 3 cycles with pc_write_cond=1, pc_src=01 in BRANCH; pc_write stays 0.
- opcode=000011 (jal) → cycle 3 shows pc_src=10, reg_dst=10, wb_sel=10, reg_write=1, then FETCH.
- opcode=111111 → with ILLEGAL_OP_TRAP_EN: state=13, illegal_op=1 held 10 cycles until reset. Without it: back to FETCH, illegal_op=0.
- Reset asserted during MEM_RD → state=0 asynchronously, mem_read=0 in the same cycle.
